ddr4_dm_lane_tx_sched: RTL and testbench

Write-path scheduler for a DDR4 data-mask lane. It sits directly upstream of the lane's DM I/O serializer, which takes 8 beats of TX data and 4 bits of output enable per fabric clock. It queues per-burst mask bytes from the controller and releases each one exactly CWL fabric cycles after its write command. It shapes the output-enable with a preamble and a postamble, and it sequences the serializer's output delay-line adjustments.

---
 rtl/ddr4_dm_lane_tx_sched.sv | 168 ++++++++++++++++
 tb/tb_ddr4_dm_lane_tx_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_dm_lane_tx_sched.sv
// DDR4 DM lane write scheduler: mask FIFO, CWL-aligned burst release, OE pre/postamble, delay-line stepping.
// Build option DDR4_DM_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter on UNDERRUN_CNT.
module ddr4_dm_lane_tx_sched #(
  parameter int FIFO_DEPTH = 8,
  parameter int CWL_MAX    = 31
) (
  input  logic        FAB_CLK,
  input  logic        TX_SYNC_RST,
  input  logic [4:0]  CWL_CFG,
  input  logic        WR_CMD,
  input  logic        WR_MASK_VALID,
  output logic        WR_MASK_READY,
  input  logic [7:0]  WR_MASK,
  output logic [7:0]  TX_DATA,
  output logic [3:0]  OE_DATA,
  output logic        BUSY,
  output logic        UNDERRUN,
  output logic [15:0] UNDERRUN_CNT,
  input  logic        DLY_REQ,
  input  logic        DLY_DIR,
  input  logic [7:0]  DLY_STEPS,
  output logic        DLY_BUSY,
  output logic        DLY_DONE,
  output logic        DLY_OOR,
  output logic        DELAY_LINE_MOVE,
  output logic        DELAY_LINE_DIRECTION,
  output logic        DELAY_LINE_LOAD,
  input  logic        DELAY_LINE_OUT_OF_RANGE
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_WAIT, S_DONE} dly_state_t;

  logic [30:0]   trk_q;
  logic [31:0]   trk_v;
  logic [30:0]   win;
  logic [4:0]    cwl;
  logic          b_now, b_ahead;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty, full, push, pop, underrun_now;
  logic [7:0]    head, tx_q, tx_d;
  logic [3:0]    oe_q, oe_d;
  logic          burst_q, underrun_q;
  dly_state_t    st_q, st_d;
  logic [7:0]    steps_q, steps_d;
  logic          dir_q, dir_d, oor_q, oor_d;

  always_comb begin
    cwl = CWL_CFG;
    if (CWL_CFG == 5'd0 || int'(CWL_CFG) > CWL_MAX) cwl = 5'd1;
  end

  // trk_v[k] is the WR_CMD seen k cycles ago (k=0 is this cycle), so the
  // bit at cwl-1 decides the registered burst for the next cycle.
  assign trk_v   = {trk_q, WR_CMD};
  assign b_now   = trk_v[cwl - 5'd1];
  assign b_ahead = (cwl >= 5'd2) ? trk_v[cwl - 5'd2] : 1'b0;
  assign win     = (31'd1 << (cwl - 5'd1)) - 31'd1;
  assign BUSY    = (|(trk_q & win)) | burst_q;

  // Mask bytes transfer on any cycle where WR_MASK_VALID and WR_MASK_READY are
  // both high; READY also rises while full on a cycle whose burst pops the head.
  assign empty         = (cnt_q == '0);
  assign full          = (cnt_q == CW'(FIFO_DEPTH));
  assign head          = mem_q[rd_ptr_q];
  assign pop           = b_now & ~empty;
  assign underrun_now  = b_now & empty;
  assign WR_MASK_READY = ~full | pop;
  assign push          = WR_MASK_VALID & WR_MASK_READY;
  assign cnt_d         = cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge FAB_CLK) begin
    if (push) mem_q[wr_ptr_q] <= WR_MASK;
  end

  always_comb begin
    tx_d = 8'hFF;
    oe_d = {b_ahead, 3'b000} | {3'b000, burst_q};
    if (b_now) begin
      tx_d = empty ? 8'h00 : ~head;
      oe_d = 4'hF;
    end
  end

  always_comb begin
    st_d    = st_q;
    steps_d = steps_q;
    dir_d   = dir_q;
    oor_d   = oor_q;
    case (st_q)
      S_IDLE: if (DLY_REQ) begin
        dir_d   = DLY_DIR;
        steps_d = DLY_STEPS;
        oor_d   = 1'b0;
        st_d    = (DLY_STEPS == 8'd0) ? S_DONE : S_MOVE;
      end
      // Taps never move while the DM pad is driven.
      S_MOVE: if (oe_q == 4'h0) st_d = S_WAIT;
      S_WAIT: begin
        steps_d = steps_q - 8'd1;
        if (DELAY_LINE_OUT_OF_RANGE) begin
          oor_d = 1'b1;
          st_d  = S_DONE;
        end else if (steps_q != 8'd1) begin
          st_d = S_MOVE;
        end else begin
          st_d = S_DONE;
        end
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      trk_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      tx_q       <= 8'hFF;
      oe_q       <= 4'h0;
      burst_q    <= 1'b0;
      underrun_q <= 1'b0;
      st_q       <= S_IDLE;
      steps_q    <= 8'd0;
      dir_q      <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      trk_q      <= trk_v[30:0];
      wr_ptr_q   <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q   <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      oe_q       <= oe_d;
      burst_q    <= b_now;
      underrun_q <= underrun_q | underrun_now;
      st_q       <= st_d;
      steps_q    <= steps_d;
      dir_q      <= dir_d;
      oor_q      <= oor_d;
    end
  end

`ifdef DDR4_DM_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) ucnt_q <= 16'd0;
    else if (underrun_now && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
  end
  assign UNDERRUN_CNT = ucnt_q;
`else
  assign UNDERRUN_CNT = 16'd0;
`endif

  assign TX_DATA              = tx_q;
  assign OE_DATA              = oe_q;
  assign UNDERRUN             = underrun_q;
  assign DLY_BUSY             = (st_q != S_IDLE);
  assign DLY_DONE             = (st_q == S_DONE);
  assign DLY_OOR              = (st_q == S_DONE) & oor_q;
  assign DELAY_LINE_MOVE      = (st_q == S_MOVE) & (oe_q == 4'h0);
  assign DELAY_LINE_DIRECTION = (st_q != S_IDLE) & dir_q;
  assign DELAY_LINE_LOAD      = 1'b0;
endmodule

// File: tb/tb_ddr4_dm_lane_tx_sched.sv
// Directed bench for ddr4_dm_lane_tx_sched: burst timing, OE shaping, FIFO limits, underrun, delay stepping, reset.
module tb_ddr4_dm_lane_tx_sched;
`ifdef DDR4_DM_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        fab_clk = 1'b0;
  logic        tx_sync_rst;
  logic [4:0]  cwl_cfg;
  logic        wr_cmd, wr_mask_valid, wr_mask_ready;
  logic [7:0]  wr_mask, tx_data;
  logic [3:0]  oe_data;
  logic        busy, underrun;
  logic [15:0] underrun_cnt;
  logic        dly_req, dly_dir;
  logic [7:0]  dly_steps;
  logic        dly_busy, dly_done, dly_oor;
  logic        dl_move, dl_dir, dl_load, dl_oor_in;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] ucnt_model = 16'd0;

  always #5 fab_clk = ~fab_clk;

  ddr4_dm_lane_tx_sched dut (
    .FAB_CLK(fab_clk), .TX_SYNC_RST(tx_sync_rst), .CWL_CFG(cwl_cfg),
    .WR_CMD(wr_cmd), .WR_MASK_VALID(wr_mask_valid), .WR_MASK_READY(wr_mask_ready),
    .WR_MASK(wr_mask), .TX_DATA(tx_data), .OE_DATA(oe_data), .BUSY(busy),
    .UNDERRUN(underrun), .UNDERRUN_CNT(underrun_cnt), .DLY_REQ(dly_req),
    .DLY_DIR(dly_dir), .DLY_STEPS(dly_steps), .DLY_BUSY(dly_busy),
    .DLY_DONE(dly_done), .DLY_OOR(dly_oor), .DELAY_LINE_MOVE(dl_move),
    .DELAY_LINE_DIRECTION(dl_dir), .DELAY_LINE_LOAD(dl_load),
    .DELAY_LINE_OUT_OF_RANGE(dl_oor_in)
  );

  task automatic step();
    @(posedge fab_clk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [7:0] m);
    wr_mask_valid = 1'b1;
    wr_mask = m;
    step();
    wr_mask_valid = 1'b0;
  endtask

  task automatic test_reset();
    tx_sync_rst = 1'b1;
    step_n(2);
    n_total++; if (tx_data !== 8'hFF) $display("FAIL reset_tx: got %h want ff", tx_data); else n_pass++;
    n_total++; if (oe_data !== 4'h0) $display("FAIL reset_oe: got %h want 0", oe_data); else n_pass++;
    n_total++; if ({wr_mask_ready, busy, underrun} !== 3'b100) $display("FAIL reset_rdy_busy_ur: got %b want 100", {wr_mask_ready, busy, underrun}); else n_pass++;
    n_total++; if (underrun_cnt !== 16'd0) $display("FAIL reset_cnt: got %h want 0", underrun_cnt); else n_pass++;
    n_total++; if ({dly_busy, dly_done, dly_oor, dl_move, dl_dir, dl_load} !== 6'b0) $display("FAIL reset_dly: got %b want 000000", {dly_busy, dly_done, dly_oor, dl_move, dl_dir, dl_load}); else n_pass++;
    tx_sync_rst = 1'b0;
    step();
  endtask

  task automatic test_single_burst();
    cwl_cfg = 5'd9;
    step_n(12);
    push(8'h0F);
    wr_cmd = 1'b1;
    step();
    wr_cmd = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    step_n(7);
    n_total++; if ({oe_data, tx_data} !== {4'b1000, 8'hFF}) $display("FAIL single_pre: got oe=%b tx=%h want oe=1000 tx=ff", oe_data, tx_data); else n_pass++;
    step();
    n_total++; if ({oe_data, tx_data} !== {4'hF, 8'hF0}) $display("FAIL single_burst: got oe=%b tx=%h want oe=1111 tx=f0", oe_data, tx_data); else n_pass++;
    step();
    n_total++; if ({oe_data, tx_data} !== {4'b0001, 8'hFF}) $display("FAIL single_post: got oe=%b tx=%h want oe=0001 tx=ff", oe_data, tx_data); else n_pass++;
    step();
    n_total++; if ({oe_data, busy} !== 5'b0000_0) $display("FAIL single_after: got oe=%b busy=%b want 0000 0", oe_data, busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_oe [6] = '{4'b1000, 4'hF, 4'hF, 4'b1001, 4'hF, 4'b0001};
    logic [7:0] exp_tx [6] = '{8'hFF, 8'hFE, 8'hFD, 8'hFF, 8'hFC, 8'hFF};
    cwl_cfg = 5'd5;
    step_n(12);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wr_cmd = 1'b1;
    step_n(2);
    wr_cmd = 1'b0;
    step();
    wr_cmd = 1'b1;
    step();
    wr_cmd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if ({oe_data, tx_data} !== {exp_oe[i], exp_tx[i]})
        $display("FAIL b2b_cycle%0d: got oe=%b tx=%h want oe=%b tx=%h", i, oe_data, tx_data, exp_oe[i], exp_tx[i]);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_underrun();
    cwl_cfg = 5'd2;
    step_n(12);
    wr_cmd = 1'b1;
    step();
    wr_cmd = 1'b0;
    n_total++; if (underrun !== 1'b0) $display("FAIL ur_before: got %b want 0", underrun); else n_pass++;
    step();
    ucnt_model = ucnt_model + 16'd1;
    n_total++; if ({oe_data, tx_data, underrun} !== {4'hF, 8'h00, 1'b1}) $display("FAIL ur_burst: got oe=%b tx=%h ur=%b want 1111 00 1", oe_data, tx_data, underrun); else n_pass++;
    n_total++; if (underrun_cnt !== (CNT_EN ? ucnt_model : 16'd0)) $display("FAIL ur_cnt1: got %0d want %0d", underrun_cnt, CNT_EN ? ucnt_model : 16'd0); else n_pass++;
    // A push on the same cycle as a pop from empty must not satisfy that pop.
    step_n(4);
    cwl_cfg = 5'd1;
    step_n(2);
    wr_cmd = 1'b1;
    wr_mask_valid = 1'b1;
    wr_mask = 8'h5A;
    step();
    wr_cmd = 1'b0;
    wr_mask_valid = 1'b0;
    ucnt_model = ucnt_model + 16'd1;
    n_total++; if (tx_data !== 8'h00) $display("FAIL ur_push_same: got %h want 00", tx_data); else n_pass++;
    n_total++; if (underrun_cnt !== (CNT_EN ? ucnt_model : 16'd0)) $display("FAIL ur_cnt2: got %0d want %0d", underrun_cnt, CNT_EN ? ucnt_model : 16'd0); else n_pass++;
    step();
    wr_cmd = 1'b1;
    step();
    wr_cmd = 1'b0;
    n_total++; if (tx_data !== 8'hA5) $display("FAIL ur_late_byte: got %h want a5", tx_data); else n_pass++;
    step_n(3);
    n_total++; if (underrun !== 1'b1) $display("FAIL ur_sticky: got %b want 1", underrun); else n_pass++;
  endtask

  task automatic test_full();
    logic [7:0] exp_tx [9] = '{8'hEE, 8'hED, 8'hEC, 8'hEB, 8'hEA, 8'hE9, 8'hE8, 8'h66, 8'h00};
    cwl_cfg = 5'd3;
    step_n(12);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        n_total++; if (wr_mask_ready !== 1'b1) $display("FAIL full_rdy_before8: got %b want 1", wr_mask_ready); else n_pass++;
      end
      push(8'h10 + 8'(i));
    end
    n_total++; if (wr_mask_ready !== 1'b0) $display("FAIL full_rdy_after8: got %b want 0", wr_mask_ready); else n_pass++;
    wr_cmd = 1'b1;
    step();
    wr_cmd = 1'b0;
    step();
    n_total++; if (wr_mask_ready !== 1'b1) $display("FAIL full_rdy_on_pop: got %b want 1", wr_mask_ready); else n_pass++;
    wr_mask_valid = 1'b1;
    wr_mask = 8'h99;
    step();
    wr_mask_valid = 1'b0;
    n_total++; if ({tx_data, wr_mask_ready} !== {8'hEF, 1'b0}) $display("FAIL full_push_pop: got tx=%h rdy=%b want ef 0", tx_data, wr_mask_ready); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      wr_cmd = (i < 9);
      if (i >= 3) begin
        n_total++;
        if (tx_data !== exp_tx[i-3]) $display("FAIL full_drain%0d: got %h want %h", i - 3, tx_data, exp_tx[i-3]);
        else n_pass++;
      end
      step();
    end
    wr_cmd = 1'b0;
    ucnt_model = ucnt_model + 16'd1;
    n_total++; if (underrun_cnt !== (CNT_EN ? ucnt_model : 16'd0)) $display("FAIL full_cnt3: got %0d want %0d", underrun_cnt, CNT_EN ? ucnt_model : 16'd0); else n_pass++;
  endtask

  task automatic run_dly(input logic [7:0] steps, input logic dir, input int oor_at,
                         output logic [15:0] mv, output logic [15:0] dn,
                         output logic oor_seen, output logic dir_seen);
    mv = '0;
    dn = '0;
    oor_seen = 1'b0;
    dir_seen = 1'b0;
    dly_req = 1'b1;
    dly_dir = dir;
    dly_steps = steps;
    step();
    dly_req = 1'b0;
    for (int k = 1; k < 15; k++) begin
      mv[k] = dl_move;
      dn[k] = dly_done;
      if (dly_done) oor_seen = dly_oor;
      if (k == 1) dir_seen = dl_dir;
      if (k == oor_at) dl_oor_in = 1'b1;
      step();
    end
    dl_oor_in = 1'b0;
  endtask

  task automatic test_delay();
    logic [15:0] mv, dn;
    logic oor_seen, dir_seen;
    step_n(4);
    run_dly(8'd4, 1'b1, 99, mv, dn, oor_seen, dir_seen);
    n_total++; if (mv !== 16'h00AA) $display("FAIL dly4_moves: got %h want 00aa", mv); else n_pass++;
    n_total++; if ({dn, oor_seen} !== {16'h0200, 1'b0}) $display("FAIL dly4_done: got done=%h oor=%b want 0200 0", dn, oor_seen); else n_pass++;
    n_total++; if ({dir_seen, dl_dir, dly_busy} !== 3'b100) $display("FAIL dly4_dir: got %b want 100", {dir_seen, dl_dir, dly_busy}); else n_pass++;
    run_dly(8'd4, 1'b1, 3, mv, dn, oor_seen, dir_seen);
    n_total++; if (mv !== 16'h000A) $display("FAIL dlyoor_moves: got %h want 000a", mv); else n_pass++;
    n_total++; if ({dn, oor_seen} !== {16'h0020, 1'b1}) $display("FAIL dlyoor_done: got done=%h oor=%b want 0020 1", dn, oor_seen); else n_pass++;
    run_dly(8'd0, 1'b0, 99, mv, dn, oor_seen, dir_seen);
    n_total++; if ({mv, dn, oor_seen} !== {16'h0000, 16'h0002, 1'b0}) $display("FAIL dly0: got mv=%h done=%h oor=%b want 0000 0002 0", mv, dn, oor_seen); else n_pass++;
  endtask

  task automatic test_delay_gating();
    logic [15:0] mv, dn;
    logic oor_seen, dir_seen;
    cwl_cfg = 5'd2;
    step_n(12);
    wr_cmd = 1'b1;
    wr_mask_valid = 1'b1;
    wr_mask = 8'h3C;
    step();
    wr_cmd = 1'b0;
    wr_mask_valid = 1'b0;
    run_dly(8'd1, 1'b0, 99, mv, dn, oor_seen, dir_seen);
    n_total++; if (mv !== 16'h0008) $display("FAIL gate_moves: got %h want 0008", mv); else n_pass++;
    n_total++; if (dn !== 16'h0020) $display("FAIL gate_done: got %h want 0020", dn); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic bad;
    cwl_cfg = 5'd10;
    step_n(12);
    dly_req = 1'b1;
    dly_dir = 1'b1;
    dly_steps = 8'd20;
    wr_cmd = 1'b1;
    step();
    dly_req = 1'b0;
    step_n(2);
    wr_cmd = 1'b0;
    n_total++; if ({busy, dly_busy} !== 2'b11) $display("FAIL rmid_busy: got %b want 11", {busy, dly_busy}); else n_pass++;
    step();
    tx_sync_rst = 1'b1;
    step();
    tx_sync_rst = 1'b0;
    n_total++; if ({tx_data, oe_data, wr_mask_ready, busy, underrun} !== {8'hFF, 4'h0, 3'b100}) $display("FAIL rmid_vals: got tx=%h oe=%b rdy/busy/ur=%b want ff 0000 100", tx_data, oe_data, {wr_mask_ready, busy, underrun}); else n_pass++;
    n_total++; if ({underrun_cnt, dly_busy, dly_done, dly_oor, dl_move, dl_dir, dl_load} !== 22'd0) $display("FAIL rmid_dly: got cnt=%h dly=%b want 0 000000", underrun_cnt, {dly_busy, dly_done, dly_oor, dl_move, dl_dir, dl_load}); else n_pass++;
    bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (tx_data !== 8'hFF || oe_data !== 4'h0 || dly_done !== 1'b0 || dl_move !== 1'b0 || underrun !== 1'b0) bad = 1'b1;
      step();
    end
    n_total++; if (bad !== 1'b0) $display("FAIL rmid_quiet: activity seen after reset"); else n_pass++;
  endtask

  initial begin
    tx_sync_rst = 1'b1;
    cwl_cfg = 5'd9;
    wr_cmd = 1'b0;
    wr_mask_valid = 1'b0;
    wr_mask = 8'h00;
    dly_req = 1'b0;
    dly_dir = 1'b0;
    dly_steps = 8'd0;
    dl_oor_in = 1'b0;
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_underrun();
    test_full();
    test_delay();
    test_delay_gating();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
